// File: rtl/exe_stage.sv
// Execute stage of the ARM-subset pipeline: operand-2 generation, ALU,
// branch-target adder, NZCV status register and a 32-step shift-add
// multiplier that stalls the front end while it iterates.
module exe_stage #(
  parameter logic [3:0] MUL_CMD   = 4'b1010,
  parameter int         MUL_STEPS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_EN_in,
  input  logic        MEM_R_EN_in,
  input  logic        MEM_W_EN_in,
  input  logic        B_in,
  input  logic        S_in,
  input  logic        imm_in,
  input  logic [3:0]  EXE_CMD_in,
  input  logic [3:0]  Dest_in,
  input  logic [11:0] shift_operand_in,
  input  logic [23:0] signed_imm_24_in,
  input  logic [31:0] PC_in,
  input  logic [31:0] Val_Rn_in,
  input  logic [31:0] Val_Rm_in,
  output logic        WB_EN_out,
  output logic        MEM_R_EN_out,
  output logic        MEM_W_EN_out,
  output logic [3:0]  Dest_out,
  output logic [31:0] ALU_result,
  output logic [31:0] Val_Rm_out,
  output logic [31:0] Br_addr,
  output logic        branch_taken,
  output logic [3:0]  status,
  output logic        stall
);

  localparam int CNT_W = $clog2(MUL_STEPS);

  localparam logic [3:0] OP_MOV = 4'b0001;
  localparam logic [3:0] OP_MVN = 4'b1001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_ADC = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SBC = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_ORR = 4'b0111;
  localparam logic [3:0] OP_EOR = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_t;

  mul_state_t       state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [31:0]      mcand_r, mcand_s;
  logic [31:0]      mplier_r, mplier_s;
  logic [31:0]      product_r, product_s;
  logic [3:0]       status_r;

  logic [31:0] val2_s;
  logic [63:0] rot_dbl_s;
  logic [63:0] ror_dbl_s;
  logic [31:0] imm_ext_s;
  logic [4:0]  shamt_s;
  logic [4:0]  rot_amt_s;

  logic [31:0] add_b_s;
  logic        cin_s;
  logic [32:0] sum_s;
  logic        ovf_s;
  logic [31:0] alu_res_s;
  logic        arith_s;
  logic        known_s;
  logic [3:0]  flags_next_s;
  logic        status_we_s;
  logic        is_mul_s;

  assign is_mul_s  = (EXE_CMD_in == MUL_CMD);
  assign shamt_s   = shift_operand_in[11:7];
  assign rot_amt_s = {shift_operand_in[11:8], 1'b0};
  assign imm_ext_s = {24'd0, shift_operand_in[7:0]};
  assign rot_dbl_s = {imm_ext_s, imm_ext_s} >> rot_amt_s;
  assign ror_dbl_s = {Val_Rm_in, Val_Rm_in} >> shamt_s;

  // Operand 2: address offset, rotated immediate, or shifted register.
  always_comb begin
    val2_s = Val_Rm_in;
    if (MEM_R_EN_in || MEM_W_EN_in) begin
      val2_s = {20'd0, shift_operand_in};
    end else if (imm_in) begin
      val2_s = rot_dbl_s[31:0];
    end else begin
      case (shift_operand_in[6:5])
        2'b00:   val2_s = Val_Rm_in << shamt_s;
        2'b01:   val2_s = Val_Rm_in >> shamt_s;
        2'b10:   val2_s = $unsigned($signed(Val_Rm_in) >>> shamt_s);
        2'b11:   val2_s = ror_dbl_s[31:0];
        default: val2_s = Val_Rm_in;
      endcase
    end
  end

  // Adder operand select; subtraction is Rn + ~Val2 + carry-in.
  always_comb begin
    add_b_s = val2_s;
    cin_s   = 1'b0;
    case (EXE_CMD_in)
      OP_ADC: begin
        add_b_s = val2_s;
        cin_s   = status_r[1];
      end
      OP_SUB: begin
        add_b_s = ~val2_s;
        cin_s   = 1'b1;
      end
      OP_SBC: begin
        add_b_s = ~val2_s;
        cin_s   = status_r[1];
      end
      default: begin
        add_b_s = val2_s;
        cin_s   = 1'b0;
      end
    endcase
  end

  assign sum_s = {1'b0, Val_Rn_in} + {1'b0, add_b_s} + {32'd0, cin_s};
  assign ovf_s = (Val_Rn_in[31] == add_b_s[31]) && (sum_s[31] != Val_Rn_in[31]);

  // ALU result select and next NZCV; unknown codes leave flags alone.
  always_comb begin
    alu_res_s = 32'd0;
    arith_s   = 1'b0;
    known_s   = 1'b1;
    case (EXE_CMD_in)
      OP_MOV:  alu_res_s = val2_s;
      OP_MVN:  alu_res_s = ~val2_s;
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
        alu_res_s = sum_s[31:0];
        arith_s   = 1'b1;
      end
      OP_AND:  alu_res_s = Val_Rn_in & val2_s;
      OP_ORR:  alu_res_s = Val_Rn_in | val2_s;
      OP_EOR:  alu_res_s = Val_Rn_in ^ val2_s;
      MUL_CMD: alu_res_s = product_r;
      default: begin
        alu_res_s = 32'd0;
        known_s   = 1'b0;
      end
    endcase
    flags_next_s = {alu_res_s[31],
                    (alu_res_s == 32'd0),
                    arith_s ? sum_s[32] : status_r[1],
                    arith_s ? ovf_s     : status_r[0]};
  end

  assign stall       = is_mul_s && (state_r != ST_DONE);
  assign status_we_s = S_in && !stall && !B_in && known_s;

  // NZCV register; written only by flag-setting, non-stalled, non-branch ops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_r <= 4'b0000;
    end else if (status_we_s) begin
      status_r <= flags_next_s;
    end else begin
      status_r <= status_r;
    end
  end

  // Multiplier state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      mcand_r   <= 32'd0;
      mplier_r  <= 32'd0;
      product_r <= 32'd0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      mcand_r   <= mcand_s;
      mplier_r  <= mplier_s;
      product_r <= product_s;
    end
  end

  // Multiplier next state: capture in IDLE, one shift-add bit per RUN cycle.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    mcand_s   = mcand_r;
    mplier_s  = mplier_r;
    product_s = product_r;
    case (state_r)
      ST_IDLE: begin
        if (is_mul_s) begin
          mcand_s   = Val_Rn_in;
          mplier_s  = Val_Rm_in;
          product_s = 32'd0;
          cnt_s     = '0;
          state_s   = ST_RUN;
        end else begin
          state_s   = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (mplier_r[0]) begin
          product_s = product_r + mcand_r;
        end else begin
          product_s = product_r;
        end
        mcand_s  = mcand_r << 1;
        mplier_s = mplier_r >> 1;
        cnt_s    = cnt_r + CNT_W'(1);
        if (cnt_r == CNT_W'(MUL_STEPS - 1)) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  assign ALU_result   = alu_res_s;
  assign WB_EN_out    = WB_EN_in    && !stall;
  assign MEM_R_EN_out = MEM_R_EN_in && !stall;
  assign MEM_W_EN_out = MEM_W_EN_in && !stall;
  assign branch_taken = B_in        && !stall;
  assign Dest_out     = Dest_in;
  assign Val_Rm_out   = Val_Rm_in;
  assign Br_addr      = PC_in + {{6{signed_imm_24_in[23]}}, signed_imm_24_in, 2'b00};
  assign status       = status_r;

endmodule
